// File: rtl/lut_ctrl_pkg.sv
// Shared types for the DFF LUT configuration controller.
package lut_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } lut_ctrl_state_t;

endpackage

// File: rtl/lut_cfg_serializer.sv
// Parallel-load, MSB-first shift register with a bit counter that flags the last bit.
module lut_cfg_serializer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             shift,
  output logic             serial_out,
  output logic             last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= word;
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign serial_out = sr_q[WIDTH-1];
  assign last       = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/lut_config_ctrl.sv
// Loads a truth table serially into a DFF LUT and arbitrates lookups so that
// no lookup ever observes a partially shifted chain.
module lut_config_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_word,
  output logic             cfg_done,
  output logic             cfg_loaded,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [SEL_W-1:0] lk_sel,
  output logic             lk_resp_valid,
  output logic             lk_resp_data,
  output logic             lut_config_in,
  output logic             lut_shift_en,
  output logic [SEL_W-1:0] lut_select,
  input  logic             lut_mux_output
);

  lut_ctrl_state_t state_q;

  logic cfg_ready_q;
  logic cfg_done_q;
  logic cfg_loaded_q;
  logic shift_en_q;
  logic lk_pend_q;
  logic lk_resp_valid_q;
  logic lk_resp_data_q;
  logic [SEL_W-1:0] lut_select_q;

  logic cfg_acc;
  logic lk_acc;
  logic ser_out;
  logic ser_last;

  assign cfg_acc = cfg_valid && cfg_ready_q;
  // Config wins a tie with a lookup; ready readiness is only in idle with a valid table.
  assign lk_ready = cfg_ready_q && cfg_loaded_q && !cfg_valid;
  assign lk_acc   = lk_valid && lk_ready;

  lut_cfg_serializer #(
    .WIDTH(WIDTH)
  ) u_serializer (
    .clock      (clock),
    .reset      (reset),
    .load       (cfg_acc),
    .word       (cfg_word),
    .shift      (shift_en_q),
    .serial_out (ser_out),
    .last       (ser_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cfg_ready_q  <= 1'b1;
      cfg_done_q   <= 1'b0;
      cfg_loaded_q <= 1'b0;
      shift_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_acc) begin
            state_q     <= StShift;
            cfg_ready_q <= 1'b0;
            shift_en_q  <= 1'b1;
          end
        end
        StShift: begin
          if (ser_last) begin
            state_q      <= StDone;
            shift_en_q   <= 1'b0;
            cfg_done_q   <= 1'b1;
            cfg_loaded_q <= 1'b1;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          cfg_done_q  <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          cfg_ready_q <= 1'b1;
          cfg_done_q  <= 1'b0;
          shift_en_q  <= 1'b0;
        end
      endcase
    end
  end

  // Select registers on acceptance; the mux output is sampled one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      lut_select_q    <= '0;
      lk_pend_q       <= 1'b0;
      lk_resp_valid_q <= 1'b0;
      lk_resp_data_q  <= 1'b0;
    end else begin
      if (lk_acc) begin
        lut_select_q <= lk_sel;
      end
      lk_pend_q       <= lk_acc;
      lk_resp_valid_q <= lk_pend_q;
      if (lk_pend_q) begin
        lk_resp_data_q <= lut_mux_output;
      end
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign cfg_done      = cfg_done_q;
  assign cfg_loaded    = cfg_loaded_q;
  assign lut_shift_en  = shift_en_q;
  assign lut_config_in = shift_en_q & ser_out;
  assign lut_select    = lut_select_q;
  assign lk_resp_valid = lk_resp_valid_q;
  assign lk_resp_data  = lk_resp_data_q;

endmodule

// File: tb/tb_lut_config_ctrl.sv
// Scoreboard bench: a truth-table model predicts every handshake, serial bit and
// lookup response; a negedge monitor compares against the controller plus a LUT model.
module tb_lut_config_ctrl;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clock;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_word;
  logic          cfg_done;
  logic          cfg_loaded;
  logic          lk_valid;
  logic          lk_ready;
  logic [SW-1:0] lk_sel;
  logic          lk_resp_valid;
  logic          lk_resp_data;
  logic          lut_config_in;
  logic          lut_shift_en;
  logic [SW-1:0] lut_select;
  logic          lut_mux_output;

  lut_config_ctrl #(
    .WIDTH(W),
    .SEL_W(SW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_word       (cfg_word),
    .cfg_done       (cfg_done),
    .cfg_loaded     (cfg_loaded),
    .lk_valid       (lk_valid),
    .lk_ready       (lk_ready),
    .lk_sel         (lk_sel),
    .lk_resp_valid  (lk_resp_valid),
    .lk_resp_data   (lk_resp_data),
    .lut_config_in  (lut_config_in),
    .lut_shift_en   (lut_shift_en),
    .lut_select     (lut_select),
    .lut_mux_output (lut_mux_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The DFF LUT itself: config chain plus read mux.
  logic [W-1:0] chain = '0;
  always @(posedge clock) if (lut_shift_en) chain <= {chain[W-2:0], lut_config_in};
  assign lut_mux_output = chain[lut_select];

  typedef struct {
    bit exp;
    int due;
  } resp_t;

  resp_t        sb[$];
  bit [W-1:0]   tbl;
  bit           loaded;
  bit           cfg_pend;
  bit [W-1:0]   pend_word;
  int           acc_cyc = -100;
  int           cyc = 0;
  int           last_done_cyc = -1;
  int           last_acc_cyc = -1;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares every cycle, then advances the model.
  always @(negedge clock) begin
    bit m_idle, m_lkr, in_shift, exp_done;
    resp_t e;
    cyc++;
    m_idle   = !cfg_pend;
    m_lkr    = m_idle && loaded && !cfg_valid;
    in_shift = cfg_pend && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + W);
    exp_done = cfg_pend && (cyc == acc_cyc + W + 1);
    chk("cfg_ready", cfg_ready, m_idle);
    chk("lk_ready", lk_ready, m_lkr);
    chk("lut_shift_en", lut_shift_en, in_shift);
    if (in_shift) chk("lut_config_in", lut_config_in, pend_word[W - 1 - (cyc - acc_cyc - 1)]);
    else          chk("lut_config_in_idle", lut_config_in, 0);
    chk("cfg_done", cfg_done, exp_done);
    if (!exp_done) chk("cfg_loaded", cfg_loaded, loaded);

    if (lk_resp_valid) begin
      if (sb.size() == 0) begin
        fail_now("lk_resp_valid_unexpected");
      end else begin
        e = sb.pop_front();
        chk("lk_resp_cycle", cyc, e.due);
        chk("lk_resp_data", lk_resp_data, e.exp);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      void'(sb.pop_front());
      fail_now("lk_resp_missing");
    end

    if (reset) begin
      cfg_pend = 1'b0;
      loaded   = 1'b0;
      sb.delete();
    end else begin
      if (exp_done) begin
        tbl           = pend_word;
        loaded        = 1'b1;
        cfg_pend      = 1'b0;
        last_done_cyc = cyc;
      end
      if (cfg_valid && m_idle) begin
        cfg_pend     = 1'b1;
        pend_word    = cfg_word;
        acc_cyc      = cyc;
        last_acc_cyc = cyc;
      end
      if (lk_valid && m_lkr) sb.push_back('{exp: tbl[lk_sel], due: cyc + 2});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [W-1:0] w);
    bit acc;
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_word  = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      acc = cfg_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("cfg_accept_timeout");
    cfg_valid = 1'b0;
    cfg_word  = W'($urandom);
  endtask

  task automatic do_lk(input logic [SW-1:0] s);
    bit acc;
    bit ok = 1'b0;
    lk_valid = 1'b1;
    lk_sel   = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      acc = lk_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("lk_accept_timeout");
    lk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (cfg_ready) return;
      step();
    end
    fail_now("idle_timeout");
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_word  = '0;
    lk_valid  = 1'b0;
    lk_sel    = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_lut_select", lut_select, 0);
    chk("reset_lk_resp_data", lk_resp_data, 0);
    chk("reset_lk_resp_valid", lk_resp_valid, 0);
    chk("reset_cfg_ready", cfg_ready, 1);

    // Unconfigured: lookups must stall.
    lk_valid = 1'b1;
    lk_sel   = 4'd5;
    repeat (5) begin
      @(negedge clock);
      chk("unconfigured_lk_ready", lk_ready, 0);
      chk("unconfigured_cfg_loaded", cfg_loaded, 0);
      step();
    end
    lk_valid = 1'b0;

    do_cfg(16'hA5C3);
    wait_idle();
    chk("loaded_after_a5c3", cfg_loaded, 1);
    do_lk(4'd0);
    do_lk(4'd2);
    do_lk(4'd15);
    repeat (3) step();

    // Simultaneous config and lookup: config wins, lookup waits for the reload.
    cfg_valid = 1'b1;
    cfg_word  = 16'hA5C3;
    lk_valid  = 1'b1;
    lk_sel    = 4'd2;
    @(negedge clock);
    chk("tie_lk_ready", lk_ready, 0);
    chk("tie_cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    do_lk(4'd2);
    repeat (2) step();
    // Lookup one cycle ahead of a reload sees the old table.
    do_lk(4'd0);
    do_cfg(16'h0001);
    wait_idle();
    do_lk(4'd15);
    repeat (3) step();

    // Reset during the 8th shift cycle.
    do_cfg(16'h1234);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midshift_shift_en", lut_shift_en, 0);
    chk("midshift_cfg_loaded", cfg_loaded, 0);
    chk("midshift_cfg_ready", cfg_ready, 1);
    do_cfg(16'hFFFF);
    wait_idle();
    do_lk(4'd7);
    repeat (3) step();

    // Config offered during SHIFT/DONE is taken in the first idle cycle.
    do_cfg(16'h3C5A);
    do_cfg(16'h8421);
    chk("accept_first_idle", last_acc_cyc, last_done_cyc + 1);
    wait_idle();
    do_lk(4'd0);
    do_lk(4'd15);
    repeat (3) step();

    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_word  = W'($urandom);
      lk_valid  = 1'($urandom_range(0, 1));
      lk_sel    = SW'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    lk_valid  = 1'b0;
    repeat (30) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
